// File: rtl/shift165_reader.sv
// Serial reader for a chain of 74HC165 shift registers: pulses shld for one
// cycle, gates WIDTH shift clocks via clk_inh, then offers the frame on valid/ready.
module shift165_reader #(
  parameter int WIDTH = 8,
  parameter int CONT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             qh,
  output logic             shld,
  output logic             clk_inh,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             shld_q, shld_d;
  logic             inh_q, inh_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    data_d  = data_q;
    valid_d = valid_q;
    // The 165 shifts on the same edge we sample, so qh is the bit on the pin now.
    shifted = (cap_q << 1) | WIDTH'(qh);

    case (state_q)
      IDLE: begin
        if (start || (CONT != 0)) state_d = LOAD;
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        cap_d = shifted;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          data_d  = shifted;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = (start || (CONT != 0)) ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin controls are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    shld_d = (state_d != LOAD);
    inh_d  = (state_d != SHIFT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      shld_q  <= 1'b1;
      inh_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      shld_q  <= shld_d;
      inh_q   <= inh_d;
      busy_q  <= busy_d;
    end
  end

  assign shld      = shld_q;
  assign clk_inh   = inh_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

endmodule
